// File: rtl/cpu_control_unit.sv
// Instruction-sequencing control unit for the 8-bit processor: fetches and decodes
// program bytes and drives every datapath control line from a five-state FSM.
module cpu_control_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              clk_ctrl,
  input  logic              rst_ctrl,
  input  logic [7:0]        instr_ctrl,
  input  logic              zero_ctrl,
  input  logic              positive_ctrl,
  output logic [ADDR_W-1:0] pc_ctrl,
  output logic [1:0]        muxsel_ctrl,
  output logic [7:0]        imm_ctrl,
  output logic              accwr_ctrl,
  output logic [2:0]        rfaddr_ctrl,
  output logic              rfwr_ctrl,
  output logic [2:0]        alusel_ctrl,
  output logic [1:0]        shiftsel_ctrl,
  output logic              outen_ctrl,
  output logic              halted_ctrl
);

  typedef enum logic [2:0] {
    FETCH   = 3'd0,
    DECODE  = 3'd1,
    OPERAND = 3'd2,
    EXEC    = 3'd3,
    HALT    = 3'd4
  } stateT;

  localparam logic [3:0] OP_NOP = 4'b0000;
  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_STA = 4'b0010;
  localparam logic [3:0] OP_LDI = 4'b0011;
  localparam logic [3:0] OP_IN  = 4'b0100;
  localparam logic [3:0] OP_OUT = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JCC = 4'b0111;

  stateT             state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [7:0]        opnd_q, opnd_d;

  logic [3:0] opcode;
  logic       isTwoByte;
  logic       isHalt;
  logic       condMet;

  assign opcode    = ir_q[7:4];
  assign isTwoByte = (opcode == OP_LDI) || (opcode == OP_JMP) || (opcode == OP_JCC);
  assign isHalt    = (opcode == OP_OUT) && ir_q[3];
  // JCOND selects JZ or JP with IR[3]; status reflects R[rrr] via muxsel=01 this cycle.
  assign condMet   = ir_q[3] ? positive_ctrl : zero_ctrl;

  always_ff @(posedge clk_ctrl) begin
    if (rst_ctrl) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      opnd_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      opnd_q  <= opnd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    opnd_d  = opnd_q;
    unique case (state_q)
      FETCH: begin
        ir_d    = instr_ctrl;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = DECODE;
      end
      DECODE: begin
        if (isTwoByte)   state_d = OPERAND;
        else if (isHalt) state_d = HALT;
        else             state_d = EXEC;
      end
      OPERAND: begin
        opnd_d  = instr_ctrl;
        pc_d    = pc_q + ADDR_W'(1);
        state_d = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        if ((opcode == OP_JMP) || ((opcode == OP_JCC) && condMet))
          pc_d = opnd_q[ADDR_W-1:0];
      end
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    muxsel_ctrl   = 2'b00;
    accwr_ctrl    = 1'b0;
    rfaddr_ctrl   = ir_q[2:0];
    rfwr_ctrl     = 1'b0;
    alusel_ctrl   = 3'b000;
    shiftsel_ctrl = 2'b00;
    outen_ctrl    = 1'b0;
    if (state_q == EXEC) begin
      if (ir_q[7]) begin
        alusel_ctrl   = ir_q[6:4];
        shiftsel_ctrl = {1'b0, ir_q[3]};
        accwr_ctrl    = 1'b1;
      end else begin
        unique case (opcode)
          OP_LDA: begin muxsel_ctrl = 2'b01; accwr_ctrl = 1'b1; end
          OP_STA: rfwr_ctrl = 1'b1;
          OP_LDI: begin muxsel_ctrl = 2'b11; accwr_ctrl = 1'b1; end
          OP_IN:  begin muxsel_ctrl = 2'b10; accwr_ctrl = 1'b1; end
          OP_OUT: outen_ctrl = ~ir_q[3];
          OP_JCC: muxsel_ctrl = 2'b01;
          default: ;
        endcase
      end
    end
    // Reset must block every register write even when it lands mid-EXEC.
    if (rst_ctrl) begin
      accwr_ctrl = 1'b0;
      rfwr_ctrl  = 1'b0;
      outen_ctrl = 1'b0;
    end
  end

  assign halted_ctrl = (state_q == HALT) && !rst_ctrl;
  assign pc_ctrl     = pc_q;
  assign imm_ctrl    = opnd_q;

endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed bench for cpu_control_unit: a combinational program memory feeds the unit
// and each step checks the control outputs against hand-derived cycle timings.
module tb_cpu_control_unit;

  logic       clk = 1'b0;
  logic       rst, rst4;
  logic [7:0] instr;
  logic [7:0] instr4;
  logic       zero, positive;
  logic [7:0] pc;
  logic [1:0] muxsel;
  logic [7:0] imm;
  logic       accwr, rfwr, outen, halted;
  logic [2:0] rfaddr, alusel;
  logic [1:0] shiftsel;

  logic [3:0] pc4;
  logic [1:0] muxsel4, shiftsel4;
  logic [7:0] imm4;
  logic       accwr4, rfwr4, outen4, halted4;
  logic [2:0] rfaddr4, alusel4;

  logic [7:0] prog  [256];
  logic [7:0] prog4 [16];
  logic       useRand;
  logic [7:0] randByte;

  int checks = 0;
  int fails  = 0;
  int curCycle = 0;

  assign instr  = useRand ? randByte : prog[pc];
  assign instr4 = prog4[pc4];

  always #5 clk = ~clk;

  cpu_control_unit #(.ADDR_W(8)) dut (
    .clk_ctrl(clk), .rst_ctrl(rst), .instr_ctrl(instr),
    .zero_ctrl(zero), .positive_ctrl(positive), .pc_ctrl(pc),
    .muxsel_ctrl(muxsel), .imm_ctrl(imm), .accwr_ctrl(accwr),
    .rfaddr_ctrl(rfaddr), .rfwr_ctrl(rfwr), .alusel_ctrl(alusel),
    .shiftsel_ctrl(shiftsel), .outen_ctrl(outen), .halted_ctrl(halted)
  );

  cpu_control_unit #(.ADDR_W(4)) dut4 (
    .clk_ctrl(clk), .rst_ctrl(rst4), .instr_ctrl(instr4),
    .zero_ctrl(zero), .positive_ctrl(positive), .pc_ctrl(pc4),
    .muxsel_ctrl(muxsel4), .imm_ctrl(imm4), .accwr_ctrl(accwr4),
    .rfaddr_ctrl(rfaddr4), .rfwr_ctrl(rfwr4), .alusel_ctrl(alusel4),
    .shiftsel_ctrl(shiftsel4), .outen_ctrl(outen4), .halted_ctrl(halted4)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        fails++;
        $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
  endtask

  task automatic applyStimulus(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk);
      #1;
      curCycle++;
    end
  endtask

  task automatic advanceTo(input int target);
    if (target > curCycle) applyStimulus(target - curCycle);
  endtask

  task automatic applyReset();
    rst  = 1'b1;
    rst4 = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    rst4 = 1'b0;
    curCycle = 0;
  endtask

  task automatic clearProg();
    for (int i = 0; i < 256; i++) prog[i] = 8'h00;
  endtask

  initial begin
    int accCnt, outCnt, outCyc, haltBad, enBad;

    rst = 1'b1; rst4 = 1'b1; zero = 1'b0; positive = 1'b0;
    useRand = 1'b0; randByte = 8'h00;
    clearProg();
    for (int i = 0; i < 16; i++) prog4[i] = 8'h00;

    // Reset values while reset is held
    @(posedge clk);
    #1;
    checkOutput("rst_pc", pc, 8'h00);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_enables", {accwr, rfwr, outen}, 3'b000);
    checkOutput("rst_muxsel", muxsel, 2'b00);
    checkOutput("rst_imm", imm, 8'h00);

    // LDI 0xA5; OUT; HALT
    prog[0] = 8'h33; prog[1] = 8'hA5; prog[2] = 8'h55; prog[3] = 8'h58;
    applyReset();
    accCnt = 0; outCnt = 0; outCyc = -1; haltBad = 0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      if (accwr) accCnt++;
      if (outen) begin outCnt++; outCyc = cyc; end
      if (cyc == 3) begin
        checkOutput("ldi_accwr", accwr, 1'b1);
        checkOutput("ldi_muxsel", muxsel, 2'b11);
        checkOutput("ldi_imm", imm, 8'hA5);
      end
      if (cyc == 8) checkOutput("halt_not_yet", halted, 1'b0);
      if (cyc >= 9 && halted !== 1'b1) haltBad++;
      applyStimulus(1);
    end
    checkOutput("accwr_pulses", accCnt, 1);
    checkOutput("outen_pulses", outCnt, 1);
    checkOutput("outen_cycle", outCyc, 6);
    checkOutput("halted_hold", haltBad, 0);
    checkOutput("halt_pc", pc, 8'h04);

    // HALT is absorbing regardless of instruction bytes and status
    useRand = 1'b1;
    enBad = 0;
    for (int i = 0; i < 20; i++) begin
      randByte = 8'($urandom);
      zero     = 1'($urandom);
      positive = 1'($urandom);
      #1;
      if (accwr || rfwr || outen) enBad++;
      applyStimulus(1);
    end
    checkOutput("halt_enables", enBad, 0);
    checkOutput("halt_pc_frozen", pc, 8'h04);
    checkOutput("halt_still", halted, 1'b1);
    useRand = 1'b0; zero = 1'b0; positive = 1'b0;
    applyReset();
    checkOutput("restart_pc0", pc, 8'h00);
    checkOutput("restart_halted", halted, 1'b0);
    applyStimulus(1);
    checkOutput("restart_fetch", pc, 8'h01);

    // LDI 3; STA r2; LDI 5; ADD r2; ALU op 101 with shift on r1
    clearProg();
    prog[0] = 8'h30; prog[1] = 8'h03; prog[2] = 8'h22; prog[3] = 8'h30;
    prog[4] = 8'h05; prog[5] = 8'h82; prog[6] = 8'hD9;
    applyReset();
    advanceTo(3);
    checkOutput("ldi3_imm", imm, 8'h03);
    advanceTo(6);
    checkOutput("sta_rfwr", rfwr, 1'b1);
    checkOutput("sta_rfaddr", rfaddr, 3'd2);
    checkOutput("sta_accwr", accwr, 1'b0);
    advanceTo(13);
    checkOutput("add_alusel", alusel, 3'b000);
    checkOutput("add_shiftsel", shiftsel, 2'b00);
    checkOutput("add_muxsel", muxsel, 2'b00);
    checkOutput("add_accwr", accwr, 1'b1);
    checkOutput("add_rfaddr", rfaddr, 3'd2);
    advanceTo(16);
    checkOutput("alu5_alusel", alusel, 3'b101);
    checkOutput("alu5_shiftsel", shiftsel, 2'b01);
    checkOutput("alu5_rfaddr", rfaddr, 3'd1);
    advanceTo(17);
    checkOutput("alu5_after", accwr, 1'b0);

    // JZ r1 taken / not taken
    clearProg();
    prog[0] = 8'h71; prog[1] = 8'h10;
    zero = 1'b1;
    applyReset();
    advanceTo(3);
    checkOutput("jz_muxsel", muxsel, 2'b01);
    checkOutput("jz_accwr", accwr, 1'b0);
    checkOutput("jz_rfaddr", rfaddr, 3'd1);
    advanceTo(4);
    checkOutput("jz_taken_pc", pc, 8'h10);
    zero = 1'b0;
    applyReset();
    advanceTo(4);
    checkOutput("jz_not_taken_pc", pc, 8'h02);

    // JP r3 not taken / taken
    prog[0] = 8'h7B; prog[1] = 8'h08;
    zero = 1'b1; positive = 1'b0;
    applyReset();
    advanceTo(4);
    checkOutput("jp_not_taken_pc", pc, 8'h02);
    zero = 1'b0; positive = 1'b1;
    applyReset();
    advanceTo(4);
    checkOutput("jp_taken_pc", pc, 8'h08);
    positive = 1'b0;

    // JMP 0xFF on the 4-bit PC variant, then wrap on the following fetch
    prog4[0] = 8'h60; prog4[1] = 8'hFF;
    applyReset();
    advanceTo(4);
    checkOutput("jmp4_pc", pc4, 4'hF);
    advanceTo(5);
    checkOutput("jmp4_wrap", pc4, 4'h0);

    // Reset landing in the EXEC of STA
    clearProg();
    prog[0] = 8'h30; prog[1] = 8'h03; prog[2] = 8'h22;
    applyReset();
    advanceTo(6);
    checkOutput("sta_pre_rst", rfwr, 1'b1);
    rst = 1'b1;
    #1;
    checkOutput("sta_rst_rfwr", rfwr, 1'b0);
    checkOutput("sta_rst_accwr", accwr, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    curCycle = 0;
    checkOutput("post_rst_pc", pc, 8'h00);
    checkOutput("post_rst_rfwr", rfwr, 1'b0);
    applyStimulus(1);
    checkOutput("post_rst_fetch", pc, 8'h01);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
